// File: rtl/digest_hex_tx_if.sv
// Bundle of the request side (start/digest/busy/done) and the UART byte
// handshake (tx_byte/tx_send/tx_sent) of the digest hex transmitter.
interface digest_hex_tx_if;
  logic         start;
  logic [127:0] digest;
  logic         busy;
  logic         done;
  logic [7:0]   tx_byte;
  logic         tx_send;
  logic         tx_sent;

  // Transmitter view: takes requests, drives the UART byte input.
  modport master (
    input  start,
    input  digest,
    input  tx_sent,
    output busy,
    output done,
    output tx_byte,
    output tx_send
  );

  // Requester/UART view.
  modport slave (
    output start,
    output digest,
    output tx_sent,
    input  busy,
    input  done,
    input  tx_byte,
    input  tx_send
  );
endinterface

// File: rtl/digest_hex_tx.sv
// Sends a captured 128-bit MD5 digest as 32 ASCII hex characters (most
// significant nibble first), optionally followed by CR LF, one character per
// UART frame. Each character is strobed only while the UART reports idle,
// then the FSM waits for the frame to start (idle low) and finish (idle high).
module digest_hex_tx #(
  parameter bit UPPERCASE   = 1'b0,
  parameter bit APPEND_CRLF = 1'b1
) (
  input logic             clock,
  input logic             reset,
  digest_hex_tx_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    NEXT      = 3'd4,
    FINISH    = 3'd5
  } state_t;

  // Index of the final character of a transfer.
  localparam logic [5:0] LAST_INDEX = APPEND_CRLF ? 6'd33 : 6'd31;

  state_t       state_r;
  state_t       state_next_s;
  logic [127:0] captured_r;
  logic [127:0] captured_next_s;
  logic [5:0]   index_r;
  logic [5:0]   index_next_s;
  logic         tx_send_s;
  logic         busy_r;
  logic         done_r;
  logic [7:0]   tx_byte_r;

  // ASCII code of one hex digit.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nibble);
    logic [7:0] result;
    if (nibble < 4'd10) begin
      result = 8'h30 + {4'h0, nibble};
    end else if (UPPERCASE) begin
      result = 8'h41 + {4'h0, nibble} - 8'd10;
    end else begin
      result = 8'h61 + {4'h0, nibble} - 8'd10;
    end
    return result;
  endfunction

  // Character sent at position idx of a transfer of word; 0x00 past the end.
  function automatic logic [7:0] char_at(input logic [127:0] word, input logic [5:0] idx);
    logic [7:0] result;
    logic [6:0] top_bit;
    top_bit = 7'd127 - {idx[4:0], 2'b00};
    if (idx < 6'd32) begin
      result = hex_ascii(word[top_bit -: 4]);
    end else if (APPEND_CRLF && (idx == 6'd32)) begin
      result = 8'h0D;
    end else if (APPEND_CRLF && (idx == 6'd33)) begin
      result = 8'h0A;
    end else begin
      result = 8'h00;
    end
    return result;
  endfunction

  // Next-state, capture/index update and the send strobe.
  always_comb begin
    state_next_s    = state_r;
    captured_next_s = captured_r;
    index_next_s    = index_r;
    tx_send_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          captured_next_s = bus.digest;
          index_next_s    = 6'd0;
          state_next_s    = ISSUE;
        end else begin
          state_next_s    = IDLE;
        end
      end
      ISSUE: begin
        // Strobe only into an idle UART; otherwise keep waiting here.
        if (bus.tx_sent) begin
          tx_send_s    = 1'b1;
          state_next_s = WAIT_LOW;
        end else begin
          state_next_s = ISSUE;
        end
      end
      WAIT_LOW: begin
        if (!bus.tx_sent) begin
          state_next_s = WAIT_HIGH;
        end else begin
          state_next_s = WAIT_LOW;
        end
      end
      WAIT_HIGH: begin
        if (bus.tx_sent) begin
          state_next_s = NEXT;
        end else begin
          state_next_s = WAIT_HIGH;
        end
      end
      NEXT: begin
        index_next_s = index_r + 6'd1;
        if (index_r == LAST_INDEX) begin
          state_next_s = FINISH;
        end else begin
          state_next_s = ISSUE;
        end
      end
      FINISH: begin
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, capture and registered status/byte outputs; the byte is loaded
  // from the next index so it is already valid in the ISSUE cycle and holds
  // until the index advances.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= IDLE;
      captured_r <= 128'd0;
      index_r    <= 6'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      tx_byte_r  <= 8'h00;
    end else begin
      state_r    <= state_next_s;
      captured_r <= captured_next_s;
      index_r    <= index_next_s;
      busy_r     <= (state_next_s != IDLE);
      done_r     <= (state_next_s == FINISH);
      tx_byte_r  <= (state_next_s == IDLE) ? 8'h00 : char_at(captured_next_s, index_next_s);
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.tx_byte = tx_byte_r;
  // Combinational so the strobe can fire in the very cycle the UART goes idle.
  assign bus.tx_send = tx_send_s;

endmodule

// File: tb/tb_digest_hex_tx.sv
// Bench for digest_hex_tx: a lowercase+CRLF instance (a) and an
// uppercase/no-CRLF instance (b), each driven by a behavioural UART.
module tb_digest_hex_tx;
  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    bit           sel;
    logic [127:0] digest;
    string        hex;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  digest_hex_tx_if bus_a ();
  digest_hex_tx_if bus_b ();

  digest_hex_tx #(.UPPERCASE(1'b0), .APPEND_CRLF(1'b1)) dut_a (
    .clock(clock), .reset(reset), .bus(bus_a.master));
  digest_hex_tx #(.UPPERCASE(1'b1), .APPEND_CRLF(1'b0)) dut_b (
    .clock(clock), .reset(reset), .bus(bus_b.master));

  // UART model: idle drops the cycle after a strobe, stays low frame_len cycles
  int frame_len = 20;
  int ucnt_a = 0;
  int ucnt_b = 0;
  bit hold_a = 1'b0;
  bit hold_b = 1'b0;

  // UART frame counters (not reset: an in-flight frame runs to completion)
  always @(posedge clock) begin
    if (bus_a.tx_send) ucnt_a <= frame_len;
    else if (ucnt_a != 0) ucnt_a <= ucnt_a - 1;
    if (bus_b.tx_send) ucnt_b <= frame_len;
    else if (ucnt_b != 0) ucnt_b <= ucnt_b - 1;
  end
  assign bus_a.tx_sent = (ucnt_a == 0) && !hold_a;
  assign bus_b.tx_sent = (ucnt_b == 0) && !hold_b;

  byte_q_t    got_a, got_b;
  int         cyc = 0;
  int         done_a = 0, done_b = 0, viol_a = 0, viol_b = 0;
  int         rise_a = 0, rise_b = 0, done_cyc_a = 0, done_cyc_b = 0;
  bit         prev_a = 1'b0, prev_b = 1'b0, track_a = 1'b0, track_b = 1'b0;
  logic [7:0] last_a = 8'h00, last_b = 8'h00;

  // Monitor: records sent bytes, done pulses, idle rises and rule violations
  always @(negedge clock) begin
    cyc    <= cyc + 1;
    prev_a <= bus_a.tx_sent;
    prev_b <= bus_b.tx_sent;
    if (!prev_a && bus_a.tx_sent) rise_a <= cyc;
    if (!prev_b && bus_b.tx_sent) rise_b <= cyc;
    if (bus_a.done) begin done_a <= done_a + 1; done_cyc_a <= cyc; end
    if (bus_b.done) begin done_b <= done_b + 1; done_cyc_b <= cyc; end
    if (reset) track_a <= 1'b0;
    else if (bus_a.tx_send) begin got_a.push_back(bus_a.tx_byte); last_a <= bus_a.tx_byte; track_a <= 1'b1; end
    if (reset) track_b <= 1'b0;
    else if (bus_b.tx_send) begin got_b.push_back(bus_b.tx_byte); last_b <= bus_b.tx_byte; track_b <= 1'b1; end
    viol_a <= viol_a + int'((bus_a.tx_send && !bus_a.tx_sent) || (bus_a.tx_send && !bus_a.busy) ||
                            (!reset && !bus_a.busy && bus_a.tx_byte != 8'h00) ||
                            (track_a && ucnt_a != 0 && !bus_a.tx_send && bus_a.tx_byte != last_a));
    viol_b <= viol_b + int'((bus_b.tx_send && !bus_b.tx_sent) || (bus_b.tx_send && !bus_b.busy) ||
                            (!reset && !bus_b.busy && bus_b.tx_byte != 8'h00) ||
                            (track_b && ucnt_b != 0 && !bus_b.tx_send && bus_b.tx_byte != last_b));
  end

  int tests = 0;
  int failed = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference: string lookup of each nibble, MSB first, optional CR LF
  function automatic void model(input logic [127:0] d, input bit upper, input bit crlf, output byte_q_t q);
    string      digits;
    logic [3:0] n;
    if (upper) digits = "0123456789ABCDEF";
    else digits = "0123456789abcdef";
    q = {};
    for (int i = 0; i < 32; i++) begin
      n = d[127 - 4*i -: 4];
      q.push_back(digits[n]);
    end
    if (crlf) begin
      q.push_back(8'h0D);
      q.push_back(8'h0A);
    end
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic drive_edge();
    @(posedge clock);
    #1;
  endtask

  function automatic bit done_of(input bit sel);
    return sel ? bus_b.done : bus_a.done;
  endfunction

  function automatic int got_size(input bit sel);
    return sel ? got_b.size() : got_a.size();
  endfunction

  task automatic clear_got();
    got_a.delete();
    got_b.delete();
  endtask

  task automatic start_xfer(input bit sel, input logic [127:0] d);
    drive_edge();
    if (sel) begin bus_b.start = 1'b1; bus_b.digest = d; end
    else begin bus_a.start = 1'b1; bus_a.digest = d; end
    drive_edge();
    if (sel) bus_b.start = 1'b0;
    else bus_a.start = 1'b0;
  endtask

  task automatic wait_done(input bit sel, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      tick();
      seen = done_of(sel);
    end
    check({name, " done seen"}, int'(seen), 1);
  endtask

  task automatic wait_sends(input bit sel, input int n, input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 6000 && !seen; c++) begin
      tick();
      seen = (got_size(sel) >= n);
    end
    check({name, " reached char"}, int'(seen), 1);
  endtask

  task automatic compare_bytes(input string name, input bit sel, input byte_q_t exp);
    byte_q_t got;
    int      bad = 0;
    if (sel) got = got_b;
    else got = got_a;
    check({name, " send count"}, got.size(), exp.size());
    for (int i = 0; i < exp.size() && i < got.size(); i++)
      if (got[i] !== exp[i]) bad++;
    check({name, " bad bytes"}, bad, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         vecs[5];
    byte_q_t      exp;
    logic [127:0] d;
    bit           sel;
    int           d0, n0, seen, gap;

    vecs[0] = '{1'b0, 128'h0123456789ABCDEF_FEDCBA9876543210, "0123456789abcdeffedcba9876543210"};
    vecs[1] = '{1'b1, {128{1'b1}},                           "FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF"};
    vecs[2] = '{1'b0, 128'h0,                                "00000000000000000000000000000000"};
    vecs[3] = '{1'b1, 128'h0123456789ABCDEF_FEDCBA9876543210, "0123456789ABCDEFFEDCBA9876543210"};
    vecs[4] = '{1'b0, 128'hDEADBEEF_00000000_CAFEF00D_A5A5A5A5, "deadbeef00000000cafef00da5a5a5a5"};

    bus_a.start = 1'b0; bus_a.digest = 128'd0;
    bus_b.start = 1'b0; bus_b.digest = 128'd0;

    // Reset state, reset priority over start, start accepted right after reset
    repeat (3) tick();
    check("reset busy", int'(bus_a.busy), 0);
    check("reset done", int'(bus_a.done), 0);
    check("reset tx_send", int'(bus_a.tx_send), 0);
    check("reset tx_byte", int'(bus_a.tx_byte), 0);
    check("reset b busy", int'(bus_b.busy), 0);
    clear_got();
    drive_edge(); bus_a.start = 1'b1; bus_a.digest = vecs[0].digest;
    drive_edge(); reset = 1'b0;
    tick();
    check("reset beats start", int'(bus_a.busy), 0);
    drive_edge(); bus_a.start = 1'b0;
    tick();
    check("start after reset busy", int'(bus_a.busy), 1);
    wait_done(1'b0, "post-reset");
    model(vecs[0].digest, 1'b0, 1'b1, exp);
    compare_bytes("post-reset", 1'b0, exp);

    // Table of fixed digests with hand-written expected characters
    foreach (vecs[k]) begin
      clear_got();
      d0 = vecs[k].sel ? done_b : done_a;
      exp = {};
      for (int i = 0; i < vecs[k].hex.len(); i++) exp.push_back(vecs[k].hex[i]);
      if (!vecs[k].sel) begin exp.push_back(8'h0D); exp.push_back(8'h0A); end
      start_xfer(vecs[k].sel, vecs[k].digest);
      wait_done(vecs[k].sel, $sformatf("vec%0d", k));
      tick();
      check($sformatf("vec%0d busy after done", k), int'(vecs[k].sel ? bus_b.busy : bus_a.busy), 0);
      check($sformatf("vec%0d done pulse width", k), int'(done_of(vecs[k].sel)), 0);
      compare_bytes($sformatf("vec%0d", k), vecs[k].sel, exp);
      check($sformatf("vec%0d done count", k), (vecs[k].sel ? done_b : done_a) - d0, 1);
      if (vecs[k].sel) check($sformatf("vec%0d done latency", k), done_cyc_b - rise_b, 2);
    end

    // UART busy at start: no strobe until idle, strobe in the rising cycle
    clear_got();
    d = 128'h13579BDF_2468ACE0_0F1E2D3C_4B5A6978;
    hold_a = 1'b1;
    start_xfer(1'b0, d);
    n0 = 0;
    repeat (100) begin tick(); if (bus_a.tx_send) n0++; end
    check("hold no strobe", n0, 0);
    check("hold still busy", int'(bus_a.busy), 1);
    drive_edge(); hold_a = 1'b0;
    tick();
    check("strobe on idle rise", int'(bus_a.tx_send), 1);
    wait_done(1'b0, "hold");
    model(d, 1'b0, 1'b1, exp);
    compare_bytes("hold", 1'b0, exp);

    // Digest change and start pulse mid-transfer, start pulse in FINISH
    clear_got();
    d = 128'hA1B2C3D4_E5F60718_293A4B5C_6D7E8F90;
    model(d, 1'b0, 1'b1, exp);
    start_xfer(1'b0, d);
    wait_sends(1'b0, 6, "midchange");
    drive_edge(); bus_a.digest = 128'd0; bus_a.start = 1'b1;
    drive_edge(); bus_a.start = 1'b0;
    wait_done(1'b0, "midchange");
    bus_a.start = 1'b1;
    drive_edge(); bus_a.start = 1'b0;
    repeat (40) tick();
    compare_bytes("midchange", 1'b0, exp);
    check("no restart after finish start", int'(bus_a.busy), 0);

    // Reset during character 10 aborts; a fresh start sends from character 0
    clear_got();
    d = 128'hFEEDFACE_C0FFEE00_11223344_55667788;
    start_xfer(1'b0, d);
    wait_sends(1'b0, 11, "abort");
    d0 = done_a;
    drive_edge(); reset = 1'b1;
    drive_edge(); reset = 1'b0;
    tick();
    check("abort busy", int'(bus_a.busy), 0);
    check("abort tx_send", int'(bus_a.tx_send), 0);
    check("abort tx_byte", int'(bus_a.tx_byte), 0);
    n0 = got_a.size();
    repeat (60) tick();
    check("abort no more sends", got_a.size(), n0);
    check("abort no done", done_a, d0);
    clear_got();
    start_xfer(1'b0, d);
    wait_done(1'b0, "after abort");
    model(d, 1'b0, 1'b1, exp);
    compare_bytes("after abort", 1'b0, exp);

    // start held high: two back-to-back transfers, one idle cycle between
    clear_got();
    d = 128'h0F0F0F0F_F0F0F0F0_12345678_9ABCDEF0;
    d0 = done_a;
    drive_edge(); bus_a.digest = d; bus_a.start = 1'b1;
    seen = 0; gap = 0;
    for (int c = 0; c < 12000 && seen < 2; c++) begin
      tick();
      if (bus_a.done) seen++;
      else if (seen == 1 && !bus_a.busy) gap++;
    end
    drive_edge(); bus_a.start = 1'b0;
    repeat (5) tick();
    check("held start done pulses seen", seen, 2);
    check("held start idle gap", gap, 1);
    check("held start done count", done_a - d0, 2);
    check("held start stops", int'(bus_a.busy), 0);
    model(d, 1'b0, 1'b1, exp);
    exp = {exp, exp};
    compare_bytes("held start", 1'b0, exp);

    // Randomised digests, instances and frame lengths against the model
    for (int r = 0; r < 6; r++) begin
      clear_got();
      sel = 1'($urandom_range(0, 1));
      d = {$urandom, $urandom, $urandom, $urandom};
      frame_len = 10 * $urandom_range(1, 3);
      model(d, sel, !sel, exp);
      start_xfer(sel, d);
      wait_done(sel, $sformatf("rand%0d", r));
      tick();
      compare_bytes($sformatf("rand%0d", r), sel, exp);
    end

    check("a protocol violations", viol_a, 0);
    check("b protocol violations", viol_b, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
